// File: rtl/game_state_ctrl.sv
// Game-state controller for the VGA runner: IDLE/RUN/PAUSE/OVER FSM with BCD score, hi-score and speed.
// Button edges and collisions are latched any time and consumed once per frame at blanking entry.
module game_state_ctrl #(
  parameter int SCORE_DIGITS     = 4,
  parameter int FRAMES_PER_POINT = 6,
  parameter int LEVEL_STEP       = 100,
  parameter int SPEED_W          = 4,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 15,
  parameter int OVER_HOLD_FRAMES = 30
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      vs,
  input  logic                      start_req,
  input  logic                      pause_req,
  input  logic                      collision,
  output logic [1:0]                game_status,
  output logic                      running,
  output logic                      frame_tick,
  output logic [SPEED_W-1:0]        speed,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam int FW = $clog2(FRAMES_PER_POINT + 2);
  localparam int LW = $clog2(LEVEL_STEP + 2);
  localparam int HW = $clog2(OVER_HOLD_FRAMES + 2);

  localparam logic [FW-1:0]      FRAME_LAST   = FW'(FRAMES_PER_POINT - 1);
  localparam logic [LW-1:0]      LEVEL_LAST   = LW'(LEVEL_STEP - 1);
  localparam logic [HW-1:0]      HOLD_LAST    = HW'(OVER_HOLD_FRAMES);
  localparam logic [SPEED_W-1:0] SPEED_INIT_V = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPEED_MAX_V  = SPEED_W'(SPEED_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t state, state_n;

  logic          vs_q;
  logic          start_q, start_qq, pause_q, pause_qq;
  logic          start_pend, pause_pend, coll_pend;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [LW-1:0] level_cnt, level_cnt_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [SW-1:0] score_n, hi_n, score_inc;
  logic [SPEED_W-1:0] speed_n;
  logic          score_full, carry;
  logic          start_rise, pause_rise;

  assign start_rise  = start_q & ~start_qq;
  assign pause_rise  = pause_q & ~pause_qq;
  assign game_status = state;

  // BCD +1 with full ripple; score_full flags the all-9s saturation point.
  always_comb begin
    score_inc  = score;
    carry      = 1'b1;
    score_full = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (score[4*i +: 4] != 4'd9) score_full = 1'b0;
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n     = state;
    score_n     = score;
    hi_n        = hi_score;
    speed_n     = speed;
    frame_cnt_n = frame_cnt;
    level_cnt_n = level_cnt;
    hold_cnt_n  = hold_cnt;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (start_pend) begin
            state_n     = RUN;
            score_n     = '0;
            speed_n     = SPEED_INIT_V;
            frame_cnt_n = '0;
            level_cnt_n = '0;
          end
        end
        RUN: begin
          if (coll_pend) begin
            state_n    = OVER;
            hold_cnt_n = '0;
            if (score > hi_score) hi_n = score;
          end else if (pause_pend) begin
            state_n = PAUSE;
          end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt_n = '0;
            if (!score_full) begin
              score_n = score_inc;
              if (level_cnt == LEVEL_LAST) begin
                level_cnt_n = '0;
                if (speed != SPEED_MAX_V) speed_n = speed + 1'b1;
              end else begin
                level_cnt_n = level_cnt + 1'b1;
              end
            end
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (pause_pend || start_pend) state_n = RUN;
        end
        OVER: begin
          if (start_pend && hold_cnt == HOLD_LAST) begin
            state_n     = RUN;
            score_n     = '0;
            speed_n     = SPEED_INIT_V;
            frame_cnt_n = '0;
            level_cnt_n = '0;
            hold_cnt_n  = '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      running    <= 1'b0;
      frame_tick <= 1'b0;
      speed      <= SPEED_INIT_V;
      score      <= '0;
      hi_score   <= '0;
      vs_q       <= 1'b0;
      start_q    <= 1'b0;
      start_qq   <= 1'b0;
      pause_q    <= 1'b0;
      pause_qq   <= 1'b0;
      start_pend <= 1'b0;
      pause_pend <= 1'b0;
      coll_pend  <= 1'b0;
      frame_cnt  <= '0;
      level_cnt  <= '0;
      hold_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      vs_q       <= vs;
      frame_tick <= vs_q & ~vs;
      start_q    <= start_req;
      start_qq   <= start_q;
      pause_q    <= pause_req;
      pause_qq   <= pause_q;
      // A new request in the tick cycle outranks the clear and carries into the next frame.
      start_pend <= start_rise | (start_pend & ~frame_tick);
      pause_pend <= pause_rise | (pause_pend & ~frame_tick);
      coll_pend  <= (collision & (state == RUN)) | (coll_pend & ~frame_tick);
      state      <= state_n;
      running    <= (state_n == RUN);
      speed      <= speed_n;
      score      <= score_n;
      hi_score   <= hi_n;
      frame_cnt  <= frame_cnt_n;
      level_cnt  <= level_cnt_n;
      hold_cnt   <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: two parameterisations share one stimulus stream and are checked
// against a points-based reference model, a constant vector table and hand-written corner sequences.
module tb_game_state_ctrl;

  logic CLK = 1'b0;
  logic RESET, vs, start_req, pause_req, collision;

  logic [1:0]  a_status, b_status;
  logic        a_running, b_running, a_tick, b_tick;
  logic [3:0]  a_speed, b_speed;
  logic [15:0] a_score, a_hi;
  logic [7:0]  b_score, b_hi;

  always #5 CLK = ~CLK;

  game_state_ctrl dut_a (
    .CLK(CLK), .RESET(RESET), .vs(vs), .start_req(start_req), .pause_req(pause_req),
    .collision(collision), .game_status(a_status), .running(a_running), .frame_tick(a_tick),
    .speed(a_speed), .score(a_score), .hi_score(a_hi)
  );

  game_state_ctrl #(
    .SCORE_DIGITS(2), .FRAMES_PER_POINT(1), .LEVEL_STEP(2), .SPEED_W(4),
    .SPEED_INIT(1), .SPEED_MAX(3), .OVER_HOLD_FRAMES(2)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .vs(vs), .start_req(start_req), .pause_req(pause_req),
    .collision(collision), .game_status(b_status), .running(b_running), .frame_tick(b_tick),
    .speed(b_speed), .score(b_score), .hi_score(b_hi)
  );

  // Reference model: game progress kept as a count of scoring RUN frames; score and speed are derived.
  typedef struct {
    int fpp, ls, sinit, smax, hold_max, digits;
  } cfg_t;

  typedef struct {
    int state, run_frames, hold, hi;
    bit vs_q, tick, s_q, s_qq, p_q, p_qq, sp, pp, cp;
  } model_t;

  cfg_t   ca, cb;
  model_t ma, mb;
  int     n_checks = 0;
  int     n_pass   = 0;

  function automatic int pts(model_t m, cfg_t c);
    int mx = 10 ** c.digits - 1;
    int p  = m.run_frames / c.fpp;
    return (p > mx) ? mx : p;
  endfunction

  function automatic int spd(model_t m, cfg_t c);
    int s = c.sinit + pts(m, c) / c.ls;
    return (s > c.smax) ? c.smax : s;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic model_t step(model_t m, cfg_t c, bit v, bit s, bit p, bit col);
    model_t n = m;
    if (m.tick) begin
      case (m.state)
        0: if (m.sp) begin n.state = 1; n.run_frames = 0; end
        1: if (m.cp) begin
             n.state = 3; n.hold = 0;
             if (pts(m, c) > m.hi) n.hi = pts(m, c);
           end else if (m.pp) n.state = 2;
           else n.run_frames = m.run_frames + 1;
        2: if (m.pp || m.sp) n.state = 1;
        default: if (m.sp && m.hold == c.hold_max) begin
                   n.state = 1; n.run_frames = 0; n.hold = 0;
                 end else if (m.hold < c.hold_max) n.hold = m.hold + 1;
      endcase
    end
    n.sp   = (m.s_q && !m.s_qq) || (m.sp && !m.tick);
    n.pp   = (m.p_q && !m.p_qq) || (m.pp && !m.tick);
    n.cp   = (col && m.state == 1) || (m.cp && !m.tick);
    n.s_qq = m.s_q;  n.s_q = s;
    n.p_qq = m.p_q;  n.p_q = p;
    n.tick = m.vs_q && !v;
    n.vs_q = v;
    return n;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = step(ma, ca, vs, start_req, pause_req, collision);
      mb = step(mb, cb, vs, start_req, pause_req, collision);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_model();
    logic [15:0] t;
    check("a_status",  a_status,  ma.state);
    check("a_running", a_running, ma.state == 1);
    check("a_tick",    a_tick,    ma.tick);
    check("a_speed",   a_speed,   spd(ma, ca));
    check("a_score",   a_score,   to_bcd(pts(ma, ca)));
    check("a_hi",      a_hi,      to_bcd(ma.hi));
    check("b_status",  b_status,  mb.state);
    check("b_running", b_running, mb.state == 1);
    check("b_speed",   b_speed,   spd(mb, cb));
    t = to_bcd(pts(mb, cb));
    check("b_score",   b_score,   t[7:0]);
    t = to_bcd(mb.hi);
    check("b_hi",      b_hi,      t[7:0]);
  endtask

  // One 6-cycle frame: vs high 4 cycles then low 2; presses in cycles 0-1, late pause in cycles 4-5.
  task automatic frame(input bit s, input bit p, input bit c, input bit late);
    for (int i = 0; i < 6; i++) begin
      vs        = (i < 4);
      start_req = s && (i < 2);
      pause_req = late ? (p && i >= 4) : (p && i < 2);
      collision = c && (i < 2);
      @(negedge CLK);
    end
    start_req = 1'b0;
    pause_req = 1'b0;
    collision = 1'b0;
  endtask

  typedef struct {
    int          n;
    bit          s, p, c, late;
    logic [1:0]  st;
    logic [15:0] sc, hi;
    logic [3:0]  spd;
  } vec_t;

  vec_t tbl [14];
  int   exp_spd [12];

  initial begin
    ca = '{6, 100, 1, 15, 30, 4};
    cb = '{1, 2, 1, 3, 2, 2};
    tbl = '{
      '{1,  0, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 4'd1},  // idle frame
      '{1,  1, 0, 0, 0, 2'd1, 16'h0000, 16'h0000, 4'd1},  // start
      '{60, 0, 0, 0, 0, 2'd1, 16'h0010, 16'h0000, 4'd1},  // 60 frames = 10 points
      '{1,  0, 1, 1, 0, 2'd3, 16'h0010, 16'h0010, 4'd1},  // collision beats pause
      '{29, 1, 0, 0, 0, 2'd3, 16'h0010, 16'h0010, 4'd1},  // early starts dropped
      '{1,  1, 0, 0, 0, 2'd3, 16'h0010, 16'h0010, 4'd1},  // 30th start still dropped
      '{1,  1, 0, 0, 0, 2'd1, 16'h0000, 16'h0010, 4'd1},  // 31st start restarts
      '{6,  0, 0, 0, 0, 2'd1, 16'h0001, 16'h0010, 4'd1},
      '{1,  0, 1, 0, 1, 2'd1, 16'h0001, 16'h0010, 4'd1},  // pause edge on tick cycle
      '{1,  0, 0, 0, 0, 2'd2, 16'h0001, 16'h0010, 4'd1},  // deferred pause lands
      '{3,  0, 0, 1, 0, 2'd2, 16'h0001, 16'h0010, 4'd1},  // collisions ignored in PAUSE
      '{1,  0, 1, 0, 0, 2'd1, 16'h0001, 16'h0010, 4'd1},  // resume
      '{5,  0, 0, 0, 0, 2'd1, 16'h0002, 16'h0010, 4'd1},
      '{1,  0, 0, 1, 0, 2'd3, 16'h0002, 16'h0010, 4'd1}   // hi keeps larger score
    };
    exp_spd = '{1, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3};

    RESET = 1'b1; vs = 1'b0; start_req = 1'b0; pause_req = 1'b0; collision = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_status",  a_status,  2'd0);
    check("rst_running", a_running, 1'b0);
    check("rst_speed",   a_speed,   4'd1);
    check("rst_score",   a_score,   16'h0000);
    check("rst_hi",      a_hi,      16'h0000);

    // frame_tick: single-cycle pulse following the registered vs fall
    vs = 1'b1;
    repeat (3) @(negedge CLK);
    vs = 1'b0;
    @(negedge CLK);
    check("tick_hi", a_tick, 1'b1);
    check("tick_b",  b_tick, 1'b1);
    @(negedge CLK);
    check("tick_lo", a_tick, 1'b0);
    check_model();

    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        frame(tbl[r].s, tbl[r].p, tbl[r].c, tbl[r].late);
        check_model();
      end
      check($sformatf("row%0d_status", r), a_status, tbl[r].st);
      check($sformatf("row%0d_score", r),  a_score,  tbl[r].sc);
      check($sformatf("row%0d_hi", r),     a_hi,     tbl[r].hi);
      check($sformatf("row%0d_speed", r),  a_speed,  tbl[r].spd);
    end

    // speed levels on dut_b (1 point per frame, 2 points per level, max 3)
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("lvl_run", b_status, 2'd1);
    for (int k = 0; k < 12; k++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("lvl_speed%0d", k + 1), b_speed, exp_spd[k]);
    end
    check("lvl_score", b_score, 8'h12);

    // score saturation on dut_b at 99
    for (int k = 0; k < 100; k++) begin
      frame(1'b0, 1'b0, 1'b0, 1'b0);
      check_model();
    end
    check("sat_score",   b_score, 8'h99);
    check("sat_speed",   b_speed, 4'd3);
    check("sat_a_score", a_score, 16'h0018);

    // asynchronous reset mid-RUN, observed before any clock edge
    #2 RESET = 1'b1;
    #1;
    check("arst_status",  a_status,  2'd0);
    check("arst_running", a_running, 1'b0);
    check("arst_tick",    a_tick,    1'b0);
    check("arst_speed",   a_speed,   4'd1);
    check("arst_score",   a_score,   16'h0000);
    check("arst_hi",      a_hi,      16'h0000);
    check("arst_b_score", b_score,   8'h00);
    check("arst_b_speed", b_speed,   4'd1);
    @(negedge CLK);
    RESET = 1'b0;

    for (int k = 0; k < 300; k++) begin
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
